// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
package pipe_ctrl_pkg;

    // Decode-stage operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file
    localparam logic [1:0] FWD_EXE = 2'b01;  // EX-stage ALU result
    localparam logic [1:0] FWD_MEM = 2'b10;  // MEM-stage ALU result
    localparam logic [1:0] FWD_LD  = 2'b11;  // MEM-stage load data

    // Front-end sequencing state
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forwarding select for a single decode-stage operand.
module pipe_fwd_sel
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       src_use,
    input  logic [4:0] e_rn,
    input  logic       e_wreg,
    input  logic       e_m2reg,
    input  logic [4:0] m_rn,
    input  logic       m_wreg,
    input  logic       m_m2reg,
    output logic [1:0] sel
);

    logic e_match;
    logic m_match;

    // r0 is hard-wired zero, so it never matches a producer
    assign e_match = src_use && (e_rn != 5'd0) && (e_rn == src);
    assign m_match = src_use && (m_rn != 5'd0) && (m_rn == src);

    // Youngest producer wins; a load still in EX cannot forward (load-use stalls it)
    always_comb begin
        sel = FWD_RF;
        if (e_match && e_wreg && !e_m2reg) begin
            sel = FWD_EXE;
        end else if (m_match && m_wreg) begin
            sel = m_m2reg ? FWD_LD : FWD_MEM;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding selects,
// load-use stall, branch flush, multi-cycle EX hold and a stall performance counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic             d_use_rs,
    input  logic             d_use_rt,
    input  logic             d_mc,
    input  logic [4:0]       e_rn,
    input  logic             e_wreg,
    input  logic             e_m2reg,
    input  logic [4:0]       m_rn,
    input  logic             m_wreg,
    input  logic             m_m2reg,
    input  logic             e_br_taken,
    input  logic             cnt_clr,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             wpcir,
    output logic             fd_flush,
    output logic             de_bubble,
    output logic             mc_start,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned CW = $clog2(MC_LAT) + 1;

    mc_state_e        state_q;
    logic [CW-1:0]    mc_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             lu;
    logic             mc_accept;

    pipe_fwd_sel u_fwd_a (
        .src     (d_rs),
        .src_use (d_use_rs),
        .e_rn    (e_rn),
        .e_wreg  (e_wreg),
        .e_m2reg (e_m2reg),
        .m_rn    (m_rn),
        .m_wreg  (m_wreg),
        .m_m2reg (m_m2reg),
        .sel     (fwda)
    );

    pipe_fwd_sel u_fwd_b (
        .src     (d_rt),
        .src_use (d_use_rt),
        .e_rn    (e_rn),
        .e_wreg  (e_wreg),
        .e_m2reg (e_m2reg),
        .m_rn    (m_rn),
        .m_wreg  (m_wreg),
        .m_m2reg (m_m2reg),
        .sel     (fwdb)
    );

    // Load in EX whose result the ID instruction needs: hold one cycle until it reaches MEM
    assign lu = e_wreg && e_m2reg && (e_rn != 5'd0) &&
                ((d_use_rs && (d_rs == e_rn)) || (d_use_rt && (d_rt == e_rn)));

    // Multi-cycle op is accepted only when nothing of higher priority is happening
    assign mc_accept = (state_q == RUN) && d_mc && !lu && !e_br_taken;

    // Pipeline register controls from state and current hazards
    always_comb begin
        wpcir     = 1'b1;
        fd_flush  = 1'b0;
        de_bubble = 1'b0;
        mc_start  = 1'b0;
        mc_busy   = 1'b0;
        if (state_q == MC_BUSY) begin
            // A taken branch cannot legally occur here; it is ignored
            wpcir     = 1'b0;
            de_bubble = 1'b1;
            mc_busy   = 1'b1;
        end else if (e_br_taken) begin
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
        end else if (lu) begin
            wpcir     = 1'b0;
            de_bubble = 1'b1;
        end else if (d_mc) begin
            mc_start  = 1'b1;
        end
    end

    // Multi-cycle sequencer: mc_cnt counts remaining EX occupancy after the start cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            mc_cnt_q <= '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mc_accept) begin
                        state_q  <= MC_BUSY;
                        mc_cnt_q <= CW'(MC_LAT - 1);
                    end
                end
                MC_BUSY: begin
                    if (mc_cnt_q == CW'(1)) begin
                        state_q  <= RUN;
                        mc_cnt_q <= '0;
                    end else begin
                        mc_cnt_q <= mc_cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q  <= RUN;
                    mc_cnt_q <= '0;
                end
            endcase
        end
    end

    // Saturating count of front-end hold cycles; clear has priority
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (cnt_clr) begin
            stall_cnt_q <= '0;
        end else if (!wpcir && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
